// File: rtl/byte_packer_pkg.sv
// Shared widths and the queue entry type for the byte-to-word packer.
package byte_packer_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES + 1);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  byte_count;
  } word_entry_t;

endpackage

// File: rtl/word_skid_queue.sv
// Two-entry register FIFO of packed words; a push is accepted when full if a pop happens in the same cycle.
module word_skid_queue
  import byte_packer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Push,
  input  word_entry_t i_Entry,
  input  logic        i_Pop,
  output word_entry_t o_Head,
  output logic        o_Full,
  output logic        o_Empty
);

  word_entry_t head_q, head_d;
  word_entry_t tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = i_Pop && (count_q != 2'd0);
    do_push = i_Push && ((count_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = i_Entry;
        else                 tail_d = i_Entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        tail_d  = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = i_Entry;
        end else begin
          head_d = tail_q;
          tail_d = i_Entry;
        end
      end
      default: ;
    endcase
  end

  // NOTE: storage is reset as well, so the head reads 0 while the queue is empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_Head  = head_q;
  assign o_Full  = (count_q == 2'd2);
  assign o_Empty = (count_q == 2'd0);

endmodule

// File: rtl/byte_word_packer.sv
// Packs a valid-qualified byte stream little-endian into words and offers them on valid/ready,
// dropping and counting words that arrive while the two-entry queue is full.
module byte_word_packer
  import byte_packer_pkg::*;
#(
  parameter int DATA_WIDTH     = LANE_W,
  parameter int BYTES_PER_WORD = LANES,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                i_Input_Data,
  input  logic                                 i_Data_Valid,
  input  logic                                 i_Flush,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] o_Output_Word,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]  o_Byte_Count,
  output logic                                 o_Word_Valid,
  input  logic                                 i_Word_Ready,
  output logic                                 o_Overflow,
  output logic [DROP_CNT_WIDTH-1:0]            o_Drop_Count
);

  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam int AW = DATA_WIDTH * BYTES_PER_WORD;

  logic [AW-1:0]             acc_q, acc_d;
  logic [CW-1:0]             lane_q, lane_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      overflow_q, overflow_d;

  logic        push_req;
  logic        pop;
  logic        drop;
  logic        q_push;
  logic        q_full;
  logic        q_empty;
  word_entry_t push_entry;
  word_entry_t head;

  // NOTE: every signal gets a default before any branch, so no path can infer a latch.
  always_comb begin
    acc_d      = acc_q;
    lane_d     = lane_q;
    push_req   = 1'b0;
    push_entry = '0;

    if (i_Data_Valid) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (lane_q == CW'(k)) acc_d[k*DATA_WIDTH +: DATA_WIDTH] = i_Input_Data;
      end
      lane_d = lane_q + CW'(1);
    end

    // The incoming byte is folded in first, so a flush that coincides with a completing byte yields one word.
    if ((lane_d == CW'(BYTES_PER_WORD)) || (i_Flush && (lane_d != '0))) begin
      push_req              = 1'b1;
      push_entry.word       = acc_d;
      push_entry.byte_count = lane_d;
      acc_d                 = '0;
      lane_d                = '0;
    end

    pop    = !q_empty && i_Word_Ready;
    drop   = push_req && q_full && !pop;
    q_push = push_req && !drop;

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    overflow_d = overflow_q || drop;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      lane_q     <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  word_skid_queue u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_Push  (q_push),
    .i_Entry (push_entry),
    .i_Pop   (pop),
    .o_Head  (head),
    .o_Full  (q_full),
    .o_Empty (q_empty)
  );

  assign o_Output_Word = head.word;
  assign o_Byte_Count  = head.byte_count;
  assign o_Word_Valid  = !q_empty;
  assign o_Overflow    = overflow_q;
  assign o_Drop_Count  = drop_cnt_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and randomized bench for byte_word_packer against a queue-based behavioural model.
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        flush;
  logic        ready;
  logic [31:0] out_word;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        overflow;
  logic [15:0] drop_count;

  byte_word_packer dut (
    .clk           (clk),
    .reset         (reset),
    .i_Input_Data  (in_data),
    .i_Data_Valid  (in_valid),
    .i_Flush       (flush),
    .o_Output_Word (out_word),
    .o_Byte_Count  (out_count),
    .o_Word_Valid  (out_valid),
    .i_Word_Ready  (ready),
    .o_Overflow    (overflow),
    .o_Drop_Count  (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  c;
  } exp_word_t;

  logic [7:0]  m_bytes[$];
  exp_word_t   m_words[$];
  int unsigned m_drops;
  logic        m_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_words.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  // Model: bytes gather in a list; four bytes or a non-empty flush make a word;
  // a word meeting a full queue with no departure that cycle is lost.
  task automatic model_update(input logic v, input logic [7:0] d, input logic f, input logic r);
    logic        popped;
    logic        was_full;
    exp_word_t   e;
    popped   = (m_words.size() > 0) && r;
    was_full = (m_words.size() == 2);
    if (v) m_bytes.push_back(d);
    if (popped) void'(m_words.pop_front());
    if ((m_bytes.size() == 4) || (f && (m_bytes.size() > 0))) begin
      e.w = 32'h0;
      foreach (m_bytes[i]) e.w[8*i +: 8] = m_bytes[i];
      e.c = 3'(m_bytes.size());
      if (was_full && !popped) begin
        if (m_drops != 32'hFFFF) m_drops++;
        m_ovf = 1'b1;
      end else begin
        m_words.push_back(e);
      end
      m_bytes.delete();
    end
  endtask

  task automatic check_model();
    string t;
    t = $sformatf("cyc%0d", cyc);
    chk({t, ".valid"}, 32'(out_valid), 32'(m_words.size() > 0));
    if (m_words.size() > 0) begin
      chk({t, ".word"}, out_word, m_words[0].w);
      chk({t, ".count"}, 32'(out_count), 32'(m_words[0].c));
    end
    chk({t, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({t, ".drops"}, 32'(drop_count), m_drops);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
    @(negedge clk);
    check_model();
    in_valid = v;
    in_data  = d;
    flush    = f;
    ready    = r;
    @(posedge clk);
    model_update(v, d, f, r);
    cyc++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    flush    = 1'b0;
    ready    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(out_valid), 32'h0);
    chk("reset.word", out_word, 32'h0);
    chk("reset.count", 32'(out_count), 32'h0);
    chk("reset.ovf", 32'(overflow), 32'h0);
    chk("reset.drops", 32'(drop_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Full word with the sink ready.
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1);
    step(1, 8'h44, 0, 1);
    #2;
    chk("full.valid", 32'(out_valid), 32'h1);
    chk("full.word", out_word, 32'h44332211);
    chk("full.count", 32'(out_count), 32'h4);
    step(0, 8'h00, 0, 1);
    #2;
    chk("full.drained", 32'(out_valid), 32'h0);

    // Partial flush, then a flush on an empty accumulator.
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    step(0, 8'h00, 1, 1);
    #2;
    chk("flush.word", out_word, 32'h0000BBAA);
    chk("flush.count", 32'(out_count), 32'h2);
    step(0, 8'h00, 1, 1);
    #2;
    chk("flush.empty_noop", 32'(out_valid), 32'h0);

    // Stalled sink: two words queue, the third is dropped.
    for (int i = 1; i <= 12; i++) step(1, 8'(i), 0, 0);
    #2;
    chk("stall.head", out_word, 32'h04030201);
    chk("stall.drops", 32'(drop_count), 32'h1);
    chk("stall.ovf", 32'(overflow), 32'h1);
    step(0, 8'h00, 0, 1);
    #2;
    chk("stall.second", out_word, 32'h08070605);
    step(0, 8'h00, 0, 1);
    #2;
    chk("stall.empty", 32'(out_valid), 32'h0);
    chk("stall.ovf_sticky", 32'(overflow), 32'h1);

    // Byte and flush together.
    step(1, 8'h77, 0, 1);
    step(1, 8'h88, 0, 1);
    step(1, 8'h99, 1, 1);
    #2;
    chk("vflush.word", out_word, 32'h00998877);
    chk("vflush.count", 32'(out_count), 32'h3);
    step(0, 8'h00, 0, 1);
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h04, 1, 1);
    #2;
    chk("vflush_full.word", out_word, 32'h04030201);
    chk("vflush_full.count", 32'(out_count), 32'h4);
    step(0, 8'h00, 0, 1);
    #2;
    chk("vflush_full.no_extra", 32'(out_valid), 32'h0);

    // Full queue with push and pop in the same cycle.
    for (int i = 0; i < 11; i++) step(1, 8'(8'h21 + i), 0, 0);
    step(1, 8'h2C, 0, 1);
    #2;
    chk("pushpop.drops", 32'(drop_count), 32'h1);
    chk("pushpop.head", out_word, 32'h28272625);
    step(0, 8'h00, 0, 1);
    #2;
    chk("pushpop.next", out_word, 32'h2C2B2A29);
    step(0, 8'h00, 0, 1);

    // Asynchronous reset with one word queued and two bytes held.
    for (int i = 0; i < 6; i++) step(1, 8'(8'hB1 + i), 0, 0);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("areset.valid", 32'(out_valid), 32'h0);
    chk("areset.ovf", 32'(overflow), 32'h0);
    chk("areset.drops", 32'(drop_count), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1, 8'hC1, 0, 1);
    step(1, 8'hC2, 0, 1);
    step(1, 8'hC3, 0, 1);
    step(1, 8'hC4, 0, 1);
    #2;
    chk("areset.new_word", out_word, 32'hC4C3C2C1);
    chk("areset.new_count", 32'(out_count), 32'h4);
    step(0, 8'h00, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           8'($urandom),
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
    end
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Sits directly downstream of data_consumer in the slow read-clock domain.
- Takes its 8-bit o_Output_Data/o_Data_Valid byte stream, which has no backpressure.
- Packs the bytes into 32-bit words and presents them on a valid/ready interface.
- A 2-entry output queue absorbs sink stalls; words that cannot be queued are dropped and counted.

Parameters:
- DATA_WIDTH, 8: width of one input byte lane.
- BYTES_PER_WORD, 4: lanes per output word; must be at least 2.
- DROP_CNT_WIDTH, 16: width of the saturating drop counter.

Ports:
- clk  input  1  single clock, the slow read-side clock.
- reset  input  1  asynchronous, active-high reset.
- i_Input_Data  input  DATA_WIDTH  byte from data_consumer.
- i_Data_Valid  input  1  byte qualifier; no ready is returned upstream.
- i_Flush  input  1  emit the current partial word, zero-padded.
- o_Output_Word  output  DATA_WIDTH*BYTES_PER_WORD  head word of the output queue.
- o_Byte_Count  output  $clog2(BYTES_PER_WORD+1)  number of valid lanes in o_Output_Word (1..BYTES_PER_WORD).
- o_Word_Valid  output  1  output queue is non-empty.
- i_Word_Ready  input  1  sink accepts the head word.
- o_Overflow  output  1  sticky flag: at least one word has been dropped.
- o_Drop_Count  output  DROP_CNT_WIDTH  number of dropped words, saturating.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - Accumulator and lane index are cleared.
  - Queue is empty, so o_Word_Valid=0.
  - o_Output_Word=0, o_Byte_Count=0, o_Overflow=0, o_Drop_Count=0.
- Reset asserted mid-word or mid-transfer discards all partial and queued data. No word is emitted on reset release.
- Lane order is little-endian:
  - The first byte of a word occupies bits [DATA_WIDTH-1:0].
  - Byte k occupies bits [DATA_WIDTH*(k+1)-1:DATA_WIDTH*k].
- Every cycle with i_Data_Valid=1 writes the byte into the current lane and increments the lane index.
- When the lane index reaches BYTES_PER_WORD, a push is requested with count=BYTES_PER_WORD. The lane index and accumulator are cleared in the same cycle.
- Flush:
  - i_Flush=1 with at least one byte accumulated requests a push of the partial word. Unused lanes are 0 and count = number of bytes held.
  - i_Flush=1 with the accumulator empty and no byte arriving is a no-op.
- i_Data_Valid and i_Flush in the same cycle: the byte is included first, then the word is flushed.
  - If that byte completes a full word, exactly one full word is pushed; there is no extra empty word.
- Latency: a pushed word appears at the queue output the cycle after the completing byte or flush is sampled. Minimum 1 cycle, with no combinational path from input to output.
- Output handshake (valid/ready):
  - Transfer occurs on a cycle where o_Word_Valid && i_Word_Ready.
  - While o_Word_Valid=1 and i_Word_Ready=0, o_Output_Word and o_Byte_Count stay stable.
  - o_Word_Valid never drops without a transfer.
  - Words leave in push order.
- Queue full (2 entries), no pop this cycle, push requested: the word is dropped, o_Drop_Count increments (holding at all-ones), o_Overflow is set. The accumulator is still cleared, so packing continues.
- Queue full with push and pop in the same cycle: the push succeeds with no drop.
- Queue empty with push and no pop: the word becomes the head next cycle.
- o_Overflow stays set until reset.

Decomposition:
- Package byte_packer_pkg holds:
  - the lane-width and word-width constants;
  - the count width localparam;
  - a typedef struct packed {word, byte_count} for queue entries.
- Top module contains the lane accumulator, lane index counter, flush logic and drop counter.
- One sub-module, word_skid_queue: a 2-entry register FIFO carrying the struct, with push/pop/full/empty and simultaneous push+pop allowed when full.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, i_Word_Ready=1 -> one cycle later o_Word_Valid=1, o_Output_Word=0x44332211, o_Byte_Count=4, transferred in that cycle.
- Bytes 0xAA,0xBB, then i_Flush alone -> word 0x0000BBAA with count 2; a second i_Flush on the empty accumulator produces no word.
- i_Word_Ready=0 while 12 bytes 0x01..0x0C stream in -> queue holds 0x04030201 and 0x08070605; the third word is dropped; o_Drop_Count=1, o_Overflow=1. Then i_Word_Ready=1 -> both words drain in order, o_Overflow stays 1.
- Byte 0x99 with i_Data_Valid=1 and i_Flush=1 on the same cycle after 0x77,0x88 -> word 0x00998877, count 3. The same stimulus after three prior bytes -> a single full word, count 4.
- Queue full, i_Word_Ready=1 on the cycle a fourth byte completes a word -> no drop, o_Drop_Count unchanged, order preserved.
- Assert reset after two bytes and with one word queued -> o_Word_Valid=0 immediately (asynchronous). After release, four new bytes produce a word containing only the new bytes.
